// File: rtl/jtag_tap_pkg.sv
// rtl/jtag_tap_pkg.sv - shared JTAG TAP state/instruction types and default codes
`ifndef IDCODE_VAL
`define IDCODE_VAL 32'h4BA0_0477
`endif

package jtag_tap_pkg;

  // 1149.1-style 4-bit state encoding
  typedef enum logic [3:0] {
    ST_EX2DR   = 4'h0,
    ST_EX1DR   = 4'h1,
    ST_SHDR    = 4'h2,
    ST_PAUSEDR = 4'h3,
    ST_SELIR   = 4'h4,
    ST_UPDR    = 4'h5,
    ST_CAPDR   = 4'h6,
    ST_SELDR   = 4'h7,
    ST_EX2IR   = 4'h8,
    ST_EX1IR   = 4'h9,
    ST_SHIR    = 4'hA,
    ST_PAUSEIR = 4'hB,
    ST_RTI     = 4'hC,
    ST_UPIR    = 4'hD,
    ST_CAPIR   = 4'hE,
    ST_TLR     = 4'hF
  } JtagState;

  typedef enum logic [4:0] {
    IDCODE = 5'h01,
    BYPASS = 5'h1F
  } JtagInstruction;

  localparam logic [4:0] IR_BASE_DEF = 5'h10;

endpackage

// File: rtl/jtag_if.sv
// rtl/jtag_if.sv - JTAG pin bundle; the target sees TCK/TMS/TDI in and TDO out
interface Jtag;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  modport Target (input tck, input tms, input tdi, output tdo);
  modport Host   (output tck, output tms, output tdi, input tdo);
endinterface

// File: rtl/jtag_tap_fsm.sv
// rtl/jtag_tap_fsm.sv - 16-state TAP controller, advancing on the synchronised TCK rise strobe
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     tck_rise_i,
  input  logic     tms_i,
  output JtagState state_o
);

  JtagState state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_TLR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tck_rise_i) begin
      case (state_q)
        ST_TLR:     state_d = tms_i ? ST_TLR     : ST_RTI;
        ST_RTI:     state_d = tms_i ? ST_SELDR   : ST_RTI;
        ST_SELDR:   state_d = tms_i ? ST_SELIR   : ST_CAPDR;
        ST_CAPDR:   state_d = tms_i ? ST_EX1DR   : ST_SHDR;
        ST_SHDR:    state_d = tms_i ? ST_EX1DR   : ST_SHDR;
        ST_EX1DR:   state_d = tms_i ? ST_UPDR    : ST_PAUSEDR;
        ST_PAUSEDR: state_d = tms_i ? ST_EX2DR   : ST_PAUSEDR;
        ST_EX2DR:   state_d = tms_i ? ST_UPDR    : ST_SHDR;
        ST_UPDR:    state_d = tms_i ? ST_SELDR   : ST_RTI;
        ST_SELIR:   state_d = tms_i ? ST_TLR     : ST_CAPIR;
        ST_CAPIR:   state_d = tms_i ? ST_EX1IR   : ST_SHIR;
        ST_SHIR:    state_d = tms_i ? ST_EX1IR   : ST_SHIR;
        ST_EX1IR:   state_d = tms_i ? ST_UPIR    : ST_PAUSEIR;
        ST_PAUSEIR: state_d = tms_i ? ST_EX2IR   : ST_PAUSEIR;
        ST_EX2IR:   state_d = tms_i ? ST_UPIR    : ST_SHIR;
        ST_UPIR:    state_d = tms_i ? ST_SELDR   : ST_RTI;
        default:    state_d = ST_TLR;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/jtag_tap_multi.sv
// rtl/jtag_tap_multi.sv - clk-domain JTAG TAP with IDCODE, BYPASS and NUM_CH user DR channels
// that hand off each Update-DR through a valid/ready pair with sticky overrun.
module jtag_tap_multi
  import jtag_tap_pkg::*;
#(
  parameter int                IR_LEN         = 5,
  parameter logic [31:0]       IDCODE_VAL     = `IDCODE_VAL,
  parameter int                NUM_CH         = 2,
  parameter int                DR_LEN_MAX     = 41,
  parameter int                CH_LEN[NUM_CH] = '{32, 41},
  parameter logic [IR_LEN-1:0] IR_BASE        = IR_LEN'(IR_BASE_DEF)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  Jtag.Target                                 tap,
  output logic                                tdo_oe_o,
  input  logic [NUM_CH-1:0][DR_LEN_MAX-1:0]   ch_cap_i,
  output logic [NUM_CH-1:0][DR_LEN_MAX-1:0]   ch_data_o,
  output logic [NUM_CH-1:0]                   ch_valid_o,
  input  logic [NUM_CH-1:0]                   ch_ready_i,
  output logic [NUM_CH-1:0]                   ch_overrun_o,
  input  logic [NUM_CH-1:0]                   ch_overrun_clr_i,
  output logic [IR_LEN-1:0]                   ir_o,
  output logic [3:0]                          state_o
);

  // One shared DR shift chain, wide enough for IDCODE and the widest channel
  localparam int DW = (DR_LEN_MAX > 32) ? DR_LEN_MAX : 32;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(IDCODE);

  function automatic logic [DW-1:0] len_mask(input int len);
    return (DW'(1) << len) - DW'(1);
  endfunction

  logic [2:0] tck_sync_q;
  logic [1:0] tms_sync_q, tdi_sync_q;
  logic       tck_rise, tck_fall, tdi;
  JtagState   state;

  logic [IR_LEN-1:0]                  ir_chain_q, ir_chain_d, ir_q, ir_d;
  logic [DW-1:0]                      dr_chain_q, dr_chain_d;
  logic                               tdo_q, tdo_d, tdo_oe_q, tdo_oe_d;
  logic [NUM_CH-1:0][DR_LEN_MAX-1:0]  ch_data_q, ch_data_d;
  logic [NUM_CH-1:0]                  ch_valid_q, ch_valid_d, ch_overrun_q, ch_overrun_d;
  logic [NUM_CH-1:0]                  sel_oh;
  logic                               sel_idcode, ir_known;
  int                                 sel_len;

  // TMS/TDI ride the same two-flop delay as TCK so they line up with the strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
    end else begin
      tck_sync_q <= {tck_sync_q[1:0], tap.tck};
      tms_sync_q <= {tms_sync_q[0], tap.tms};
      tdi_sync_q <= {tdi_sync_q[0], tap.tdi};
    end
  end

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tdi      = tdi_sync_q[1];

  jtag_tap_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .tck_rise_i (tck_rise),
    .tms_i      (tms_sync_q[1]),
    .state_o    (state)
  );

  always_comb begin
    sel_idcode = (ir_q == IR_IDCODE);
    sel_oh     = '0;
    sel_len    = sel_idcode ? 32 : 1;
    ir_known   = (ir_chain_q == IR_IDCODE);
    for (int i = 0; i < NUM_CH; i++) begin
      if (ir_q == IR_BASE + IR_LEN'(i)) begin
        sel_oh[i] = 1'b1;
        sel_len   = CH_LEN[i];
      end
      if (ir_chain_q == IR_BASE + IR_LEN'(i)) ir_known = 1'b1;
    end
  end

  always_comb begin
    ir_chain_d   = ir_chain_q;
    ir_d         = ir_q;
    dr_chain_d   = dr_chain_q;
    tdo_d        = tdo_q;
    tdo_oe_d     = tdo_oe_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = ch_valid_q & ~ch_ready_i;
    ch_overrun_d = ch_overrun_q & ~ch_overrun_clr_i;

    if (state == ST_TLR) begin
      ir_d       = IR_IDCODE;
      ir_chain_d = '0;
    end

    if (tck_rise) begin
      case (state)
        ST_CAPIR: ir_chain_d = IR_LEN'(1);
        ST_SHIR:  ir_chain_d = {tdi, ir_chain_q[IR_LEN-1:1]};
        ST_CAPDR: begin
          dr_chain_d = sel_idcode ? DW'(IDCODE_VAL) : '0;
          for (int i = 0; i < NUM_CH; i++)
            if (sel_oh[i]) dr_chain_d = DW'(ch_cap_i[i]) & len_mask(CH_LEN[i]);
        end
        ST_SHDR:  dr_chain_d = (dr_chain_q >> 1) | (DW'(tdi) << (sel_len - 1));
        default:  ;
      endcase
    end

    if (tck_fall) begin
      tdo_d    = (state == ST_SHIR) ? ir_chain_q[0] : dr_chain_q[0];
      tdo_oe_d = (state == ST_SHIR) || (state == ST_SHDR);
      if (state == ST_UPIR) ir_d = ir_known ? ir_chain_q : '1;
      if (state == ST_UPDR) begin
        // Ready in the same clk frees the slot, so the new word is taken, not dropped
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel_oh[i]) begin
            if (!ch_valid_q[i] || ch_ready_i[i]) begin
              ch_data_d[i]  = DR_LEN_MAX'(dr_chain_q & len_mask(CH_LEN[i]));
              ch_valid_d[i] = 1'b1;
            end else begin
              ch_overrun_d[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_chain_q   <= '0;
      ir_q         <= IR_IDCODE;
      dr_chain_q   <= '0;
      tdo_q        <= 1'b0;
      tdo_oe_q     <= 1'b0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      ch_overrun_q <= '0;
    end else begin
      ir_chain_q   <= ir_chain_d;
      ir_q         <= ir_d;
      dr_chain_q   <= dr_chain_d;
      tdo_q        <= tdo_d;
      tdo_oe_q     <= tdo_oe_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      ch_overrun_q <= ch_overrun_d;
    end
  end

  assign tap.tdo      = tdo_q;
  assign tdo_oe_o     = tdo_oe_q;
  assign ch_data_o    = ch_data_q;
  assign ch_valid_o   = ch_valid_q;
  assign ch_overrun_o = ch_overrun_q;
  assign ir_o         = ir_q;
  assign state_o      = state;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// tb/tb_jtag_tap_multi.sv - directed table-driven bench for jtag_tap_multi
module tb_jtag_tap_multi;
  import jtag_tap_pkg::*;

  localparam logic [31:0] IDC  = 32'h5A3C_9E17;
  localparam logic [40:0] CAP0 = 41'h1FF_DEAD_BEEF;
  localparam logic [40:0] CAP1 = 41'h1_2345_6789_AB;
  localparam logic [40:0] V1   = 41'h155_5555_5555;
  localparam logic [40:0] V2   = 41'h0AA_AAAA_AAAA;

  typedef struct {
    logic [4:0]  ir;
    int          len;
    logic [63:0] din;
    logic [63:0] exp_tdo;
    logic [4:0]  exp_ir;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  Jtag jtag_if ();

  logic              tdo_oe;
  logic [1:0][40:0]  ch_cap, ch_data;
  logic [1:0]        ch_valid, ch_ready, ch_ov, ch_clr;
  logic [4:0]        ir;
  logic [3:0]        state;
  int                checks = 0;
  int                passed = 0;
  vec_t              vecs [5];

  always #5 clk = ~clk;

  jtag_tap_multi #(
    .IR_LEN     (5),
    .IDCODE_VAL (IDC),
    .NUM_CH     (2),
    .DR_LEN_MAX (41),
    .CH_LEN     ('{32, 41}),
    .IR_BASE    (5'h10)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tap              (jtag_if),
    .tdo_oe_o         (tdo_oe),
    .ch_cap_i         (ch_cap),
    .ch_data_o        (ch_data),
    .ch_valid_o       (ch_valid),
    .ch_ready_i       (ch_ready),
    .ch_overrun_o     (ch_ov),
    .ch_overrun_clr_i (ch_clr),
    .ir_o             (ir),
    .state_o          (state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One TCK period: TMS/TDI set while low, TDO sampled just before the rise
  task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo);
    jtag_if.tms = tms;
    jtag_if.tdi = tdi;
    repeat (4) @(negedge clk);
    tdo = jtag_if.tdo;
    jtag_if.tck = 1'b1;
    repeat (4) @(negedge clk);
    jtag_if.tck = 1'b0;
  endtask

  task automatic shift_ir(input logic [4:0] code, output logic [4:0] cap);
    logic t;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      tck_cycle(i == 4, code[i], t);
      cap[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
  endtask

  task automatic shift_dr(input int len, input logic [63:0] din, input bit chk_upd,
                          output logic [63:0] dout);
    logic t;
    dout = '0;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], t);
      dout[i] = t;
    end
    tck_cycle(1'b1, 1'b0, t);
    if (chk_upd) begin
      repeat (2) @(negedge clk);
      check("upd_valid_before", {63'd0, ch_valid[0]}, 64'd0);
      @(negedge clk);
      check("upd_valid_one_clk", {63'd0, ch_valid[0]}, 64'd1);
    end
    tck_cycle(1'b0, 1'b0, t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [4:0]  c;
    logic        t;

    jtag_if.tck = 1'b0;
    jtag_if.tms = 1'b0;
    jtag_if.tdi = 1'b0;
    ch_cap[0] = CAP0;
    ch_cap[1] = CAP1;
    ch_ready  = 2'b11;
    ch_clr    = 2'b00;

    vecs[0] = '{5'h01, 32, 64'h0,                {32'h0, IDC},         5'h01};
    vecs[1] = '{5'h1F, 9,  64'h0A5,              64'h14A,              5'h1F};
    vecs[2] = '{5'h07, 4,  64'hB,                64'h6,                5'h1F};
    vecs[3] = '{5'h10, 32, 64'hCAFE_F00D,        64'hDEAD_BEEF,        5'h10};
    vecs[4] = '{5'h11, 41, 64'h0AB_CDEF_0123,    {23'h0, CAP1},        5'h11};

    repeat (3) @(negedge clk);
    check("rst_state",  {60'd0, state},    {60'd0, ST_TLR});
    check("rst_ir",     {59'd0, ir},       64'h01);
    check("rst_tdo_oe", {63'd0, tdo_oe},   64'd0);
    check("rst_valid",  {62'd0, ch_valid}, 64'd0);
    check("rst_data",   {22'd0, ch_data},  64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0, t);
    check("tlr_after_5", {60'd0, state}, {60'd0, ST_TLR});
    tck_cycle(1'b0, 1'b0, t);
    repeat (4) @(negedge clk);
    check("rti", {60'd0, state}, {60'd0, ST_RTI});

    shift_dr(32, 64'h0, 1'b0, d);
    check("idcode_default", d, {32'h0, IDC});

    for (int v = 0; v < 5; v++) begin
      shift_ir(vecs[v].ir, c);
      check("ir_capture", {59'd0, c}, 64'h01);
      check("ir_decode", {59'd0, ir}, {59'd0, vecs[v].exp_ir});
      shift_dr(vecs[v].len, vecs[v].din, 1'b0, d);
      check("dr_tdo", d, vecs[v].exp_tdo);
      check("back_in_rti", {60'd0, state}, {60'd0, ST_RTI});
    end
    check("tbl_ch0_data", {23'd0, ch_data[0]}, 64'hCAFE_F00D);
    check("tbl_ch1_data", {23'd0, ch_data[1]}, 64'h0AB_CDEF_0123);
    check("tbl_valid_drained", {62'd0, ch_valid}, 64'd0);

    ch_ready = 2'b00;
    shift_ir(5'h10, c);
    shift_dr(32, 64'h1234_5678, 1'b1, d);
    check("ch0_tdo", d, 64'hDEAD_BEEF);
    check("ch0_data", {23'd0, ch_data[0]}, 64'h1234_5678);
    check("ch0_valid_held", {63'd0, ch_valid[0]}, 64'd1);

    shift_ir(5'h11, c);
    shift_dr(41, {23'd0, V1}, 1'b0, d);
    check("ch1_tdo", d, {23'd0, CAP1});
    check("ch1_data_first", {23'd0, ch_data[1]}, {23'd0, V1});
    check("ch1_ov_clear", {63'd0, ch_ov[1]}, 64'd0);
    shift_dr(41, {23'd0, V2}, 1'b0, d);
    check("ch1_data_kept", {23'd0, ch_data[1]}, {23'd0, V1});
    check("ch1_ov_set", {62'd0, ch_ov}, 64'b10);
    @(negedge clk) ch_clr = 2'b10;
    @(negedge clk) ch_clr = 2'b00;
    check("ch1_ov_cleared", {62'd0, ch_ov}, 64'd0);
    @(negedge clk) ch_ready = 2'b10;
    @(negedge clk) ch_ready = 2'b00;
    check("ch1_ready_drain", {62'd0, ch_valid}, 64'b01);

    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, i[0], t);
    @(negedge clk);
    check("mid_shift_state", {60'd0, state}, {60'd0, ST_SHDR});
    check("mid_shift_oe", {63'd0, tdo_oe}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_state", {60'd0, state}, {60'd0, ST_TLR});
    check("abort_valid", {62'd0, ch_valid}, 64'd0);
    check("abort_oe", {63'd0, tdo_oe}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tck_cycle(1'b1, 1'b0, t);
    tck_cycle(1'b0, 1'b0, t);
    repeat (4) @(negedge clk);
    check("post_abort_ir", {59'd0, ir}, 64'h01);
    check("post_abort_valid", {62'd0, ch_valid}, 64'd0);
    check("post_abort_data", {22'd0, ch_data}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/jtag_tap_multi.md
JTAG_TAP_MULTI -- requirements
Module: jtag_tap_multi

Interface
REQ-001 SHALL have parameter IR_LEN, default 5, instruction register width.
REQ-002 SHALL have parameter IDCODE_VAL, default `IDCODE_VAL, 32-bit value captured by IDCODE.
REQ-003 SHALL have parameter NUM_CH, default 2, number of user data-register channels (1..8).
REQ-004 SHALL have parameter DR_LEN_MAX, default 41, widest channel.
REQ-005 SHALL have parameter CH_LEN, int array [NUM_CH], default '{32,41}, per-channel scan length (2..DR_LEN_MAX).
REQ-006 SHALL have parameter IR_BASE, default 5'h10, IR code of channel 0; channel i decodes at IR_BASE+i.
REQ-007 SHALL have port clk  input  1  system clock; all state in this domain.
REQ-008 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have port tap  Jtag.Target  -  TCK/TMS/TDI in, TDO out.
REQ-010 SHALL have port tdo_oe_o  output  1  high only while in Shift-IR or Shift-DR.
REQ-011 SHALL have port ch_cap_i  input  NUM_CH x DR_LEN_MAX  per-channel capture value; bits >= CH_LEN[i] ignored.
REQ-012 SHALL have port ch_data_o  output  NUM_CH x DR_LEN_MAX  last accepted update value; bits >= CH_LEN[i] zero.
REQ-013 SHALL have port ch_valid_o / ch_ready_i  out/in  NUM_CH  per-channel update handshake.
REQ-014 SHALL have port ch_overrun_o / ch_overrun_clr_i  out/in  NUM_CH  sticky dropped-update flag and its clear.
REQ-015 SHALL have port ir_o  output  IR_LEN  active instruction; state_o  output  4  current TAP state (JtagState).

Function
REQ-016 SHALL synchronise TCK through two flops, derive one-clk tck_rise/tck_fall strobes from a third; TCK high and low phases each >= 3 clk.
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on tck_rise using TMS sampled at that strobe; five TCK rises with TMS=1 reach Test-Logic-Reset from any state.
REQ-018 SHALL on tck_rise: Capture-IR loads 'b01 into IR chain; Shift-IR shifts TDI into MSB, LSB out.
REQ-019 SHALL on tck_rise in Capture-DR load selected chain: IDCODE -> IDCODE_VAL, channel i -> ch_cap_i[i][CH_LEN[i]-1:0], otherwise bypass bit -> 0.
REQ-020 SHALL on tck_rise in Shift-DR shift selected chain right, inserting TDI at bit CH_LEN[i]-1 (31 for IDCODE, 0 for bypass).
REQ-021 SHALL drive TDO on tck_fall from bit 0 of IR chain (Shift-IR) or selected DR chain (otherwise); tdo_oe_o follows same strobe.
REQ-022 SHALL on tck_fall in Update-IR load ir_o from IR chain; all-ones and any undecoded code select BYPASS.
REQ-023 SHALL on tck_fall in Update-DR for channel i: if ch_valid_o[i]=0, load ch_data_o[i] and set ch_valid_o[i] the same clk.
REQ-024 SHALL hold ch_valid_o[i] until a clk with ch_ready_i[i]=1, clearing it that edge; ch_data_o stable while valid.
REQ-025 SHALL, if Update-DR hits channel i while ch_valid_o[i]=1 and ch_ready_i[i]=0, discard new data and set ch_overrun_o[i]; with ready=1 same clk, accept new data and keep valid high.
REQ-026 SHALL clear ch_overrun_o[i] on ch_overrun_clr_i[i]; a simultaneous set wins.
REQ-027 SHALL in Test-Logic-Reset set ir_o=IDCODE and zero IR chain; ch_data_o/ch_valid_o/ch_overrun_o retain value (only rst_n clears them).

Reset
REQ-028 SHALL on rst_n=0 asynchronously set: state Test-Logic-Reset, ir_o IDCODE, all chains 0, TDO 0, tdo_oe_o 0, ch_data_o 0, ch_valid_o 0, ch_overrun_o 0, TCK synchronisers 0.
REQ-029 SHALL abort any scan in progress on rst_n mid-shift; no Update output results from the aborted scan.

Structure
REQ-030 SHALL place JtagState, JtagInstruction (IDCODE, BYPASS) and IR_BASE default in the shared jtag_tap package.
REQ-031 SHALL instantiate one sub-module jtag_tap_fsm (state register + next-state logic, inputs tck_rise/TMS).

Verification
REQ-032 SHALL check: rst_n release, 5 TMS=1 clocks, Shift-DR 32 bits -> TDO returns IDCODE_VAL LSB first.
REQ-033 SHALL check: IR=0x10, ch_cap_i[0]=32'hDEADBEEF, shift in 32'h12345678 -> TDO DEADBEEF, ch_data_o[0]=12345678, ch_valid_o[0]=1 one clk after Update-DR.
REQ-034 SHALL check: IR=0x11, ready held 0, two 41-bit updates -> first value kept, ch_overrun_o[1]=1; clr pulse -> 0.
REQ-035 SHALL check: IR=0x1F, shift 8 bits 8'hA5 -> TDO emits 0 then A5 delayed one bit.
REQ-036 SHALL check: rst_n asserted mid Shift-DR of channel 1 -> state Test-Logic-Reset, ch_valid_o=0, tdo_oe_o=0 immediately.
